// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
// Module parameters default to these values so every instance agrees on one source.
package mips_rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_LINK_REG = 31;
  localparam int REG_ZERO    = 0;

  // LSB position of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue and cleared by writeback.
// A set and a clear landing on the same register in one cycle leaves the bit set.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int ZERO_REG_EN = 1,
  parameter int LINK_REG    = RF_LINK_REG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_commit,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 link_en,
  input  logic                 pend_set,
  input  logic [ADDR_W-1:0]    pend_addr,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 any_pending
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending_reg;
  logic [DEPTH-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;

      // Register 0 never becomes pending while it is hard-wired to zero.
      assign set_hit = pend_set && (pend_addr == ADDR_W'(gi))
                       && !((ZERO_REG_EN != 0) && (gi == REG_ZERO));
      assign clr_hit = (wr_commit && (wr_addr == ADDR_W'(gi)))
                       || (link_en && (gi == LINK_REG));

      always_comb begin
        pending_next[gi] = pending_reg[gi];
        if (set_hit) begin
          pending_next[gi] = 1'b1;
        end else if (clr_hit) begin
          pending_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending     = pending_reg;
  assign any_pending = |pending_reg;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS GPR file with write/link bypass and a pending-write scoreboard.
// Reads are combinational; writes, link writes and scoreboard updates land on the rising edge.
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int N_READ      = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int LINK_REG    = RF_LINK_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_READ*ADDR_W-1:0] rd_addr,
  output logic [N_READ*DATA_W-1:0] rd_data,
  output logic [N_READ-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     any_pending
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  generate
    if (LINK_REG < 0 || LINK_REG >= DEPTH) begin : g_bad_link_reg
      $error("mips_regfile_mp: LINK_REG out of range for ADDR_W");
    end
    if (N_READ < 1 || N_READ > 4) begin : g_bad_n_read
      $error("mips_regfile_mp: N_READ must be 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_commit;

  // A general write to r0 is dropped outright, so it neither stores, bypasses nor clears.
  assign wr_commit = wr_en && !((ZERO_REG_EN != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic wr_hit;
      logic link_hit;

      assign wr_hit   = wr_commit && (wr_addr == ADDR_W'(gi));
      assign link_hit = link_en && (gi == LINK_REG);

      // Link port has priority when both ports target the link register.
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (link_hit) begin
          regs_reg[gi] <= link_data;
        end else if (wr_hit) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end

    for (gi = 0; gi < N_READ; gi++) begin : g_port
      localparam int A_LSB = slice_lsb(gi, ADDR_W);
      localparam int D_LSB = slice_lsb(gi, DATA_W);

      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              is_zero;
      logic              link_byp;
      logic              wr_byp;

      assign addr     = rd_addr[A_LSB +: ADDR_W];
      assign is_zero  = (ZERO_REG_EN != 0) && (addr == ADDR_W'(REG_ZERO));
      assign link_byp = link_en && (addr == LINK_ADDR);
      assign wr_byp   = wr_commit && (addr == wr_addr);

      always_comb begin
        data = regs_reg[addr];
        if (is_zero) begin
          data = '0;
        end else if (link_byp) begin
          data = link_data;
        end else if (wr_byp) begin
          data = wr_data;
        end
      end

      assign rd_data[D_LSB +: DATA_W] = data;
      // A producer writing back this cycle is already bypassed, so the operand is usable.
      assign rd_busy[gi] = pending[addr] && !is_zero && !link_byp && !wr_byp;
    end
  endgenerate

  mips_rf_scoreboard #(
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN),
    .LINK_REG    (LINK_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_commit   (wr_commit),
    .wr_addr     (wr_addr),
    .link_en     (link_en),
    .pend_set    (pend_set),
    .pend_addr   (pend_addr),
    .pending     (pending),
    .any_pending (any_pending)
  );

endmodule

// File: doc/mips_regfile_mp.md
Name: mips_regfile_mp

Overview:
- Parametrised multi-read-port MIPS general-purpose register file.
- Adds a same-cycle write-to-read bypass, a dedicated link-register write port for JAL/JALR, and a pending-write scoreboard that flags operands with an in-flight producer (load or multi-cycle op).
- Sits between decode (read ports, scoreboard query) and writeback (write ports) in the pipelined core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- N_READ, 2, number of independent read ports (1..4).
- ZERO_REG_EN, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- LINK_REG, 31, index written by the link port.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  N_READ*ADDR_W  packed read addresses; port i is at [i*ADDR_W +: ADDR_W].
- rd_data  out  N_READ*DATA_W  packed read data, same packing.
- rd_busy  out  N_READ  port i operand has an outstanding producer.
- wr_en  in  1  general write enable.
- wr_addr  in  ADDR_W  general write address.
- wr_data  in  DATA_W  general write data.
- link_en  in  1  link write enable (JAL/JALR retire).
- link_data  in  DATA_W  return address, written unmodified; caller supplies the final value.
- pend_set  in  1  mark pend_addr as having an in-flight producer.
- pend_addr  in  ADDR_W  register to mark.
- any_pending  out  1  OR of all pending bits.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, all registers clear to 0 and all pending bits clear. rd_data then reads 0, rd_busy=0, any_pending=0. Writes, link and pend_set in a reset cycle are discarded. A reset mid-pending aborts all scoreboard entries.
- Write: at a rising edge with wr_en=1, registers[wr_addr] is loaded with wr_data. With ZERO_REG_EN=1 and wr_addr=0 the write is dropped.
- Link write: at a rising edge with link_en=1, registers[LINK_REG] is loaded with link_data.
  - If wr_en and link_en both target LINK_REG in the same cycle, link_data wins.
  - Writes to different registers in the same cycle both commit.
- Read: combinational, zero latency. Per port, priority is:
  1. zero-register rule (ZERO_REG_EN=1 and addr=0) gives 0;
  2. link bypass (link_en and addr=LINK_REG) gives link_data;
  3. write bypass (wr_en and addr=wr_addr, addr nonzero) gives wr_data;
  4. otherwise the stored value.
  - A read in the same cycle as a write therefore returns the new value.
- Scoreboard: one pending bit per register.
  - Set at a rising edge when pend_set=1, except register 0 with ZERO_REG_EN=1.
  - Cleared at a rising edge when a general or link write commits to that register.
  - Simultaneous set and clear of the same register: set wins, because a new producer has issued.
  - Setting an already-pending bit is a no-op; there is no count, and the newest producer is tracked only by its final writeback.
- rd_busy[i] = pending[rd_addr_i] AND NOT (a write or link write to rd_addr_i in this cycle). Bypassed data is valid, so it is not busy. Always 0 for register 0 with ZERO_REG_EN=1.
- any_pending is registered state only; it ignores same-cycle clears.
- Width rules: no arithmetic on data. Addresses compare on full ADDR_W. Out-of-range LINK_REG (>= 2**ADDR_W) is an elaboration error.

Decomposition:
- Package mips_rf_pkg holds:
  - default constants DATA_W=32, ADDR_W=5, LINK_REG=31, REG_ZERO=0;
  - a helper function for packed-port slicing.
- Sub-module mips_rf_scoreboard holds the pending-bit vector, the set/clear priority, and any_pending. It takes the committed write and link addresses and enables as clear inputs.
- The top module holds storage, the bypass muxes, and the per-port rd_busy masking.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst for one cycle, read r5 on ports 0 and 1 -> 0x00000000; rd_busy=0; any_pending=0.
- Bypass and zero register: wr_en=1, wr_addr=7, wr_data=0x12345678 with rd_addr0=7 in the same cycle -> rd_data0=0x12345678 combinationally. Write 0xFFFFFFFF to r0, then read r0 -> 0.
- Link collision: wr_en to r31 with 0xAAAA0000 and link_en with link_data=0x00400108 in the same cycle -> r31=0x00400108 next cycle. A concurrent write to r4 with 0x5 also commits.
- Scoreboard lifecycle:
  - pend_set r9 -> next cycle rd_addr1=9 gives rd_busy1=1, any_pending=1.
  - Write r9=0x77 -> rd_busy1=0 in that cycle with rd_data1=0x77; bit cleared after the edge.
- Set/clear race: r3 pending; same cycle wr_en to r3 and pend_set r3 -> r3 still pending afterwards. A later write clears it. Repeat with pend_set r0 -> never pending.
- N_READ=4 build: four distinct addresses read simultaneously during one write -> each port returns the correct stored or bypassed value.
